alu_iterative: RTL and testbench

ALU_ITERATIVE -- requirements
Module: alu_iterative

---
 rtl/alu_iterative.sv | 102 ++++++++++
 tb/tb_alu_iterative.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/alu_iterative.sv
// Multi-cycle ALU: one operation per start request, SRL done one bit per cycle.
// Result and Zero flag are registered and only change on the edge that enters DONE.
module alu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [3:0]       ALU_Operation_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] ALU_Result_o,
  output logic             Zero_o
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_LUI = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q;
  logic [3:0]       op_q;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] alu_res;
  logic             shifting;

  assign shifting = (op_q == OP_SRL) && (cnt != '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_next = state;
    case (state)
      IDLE:    if (start_i) state_next = EXEC;
      EXEC:    if (!shifting) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // By the time the counter reaches zero a_q already holds the fully shifted operand.
  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = a_q + b_q;
      OP_SUB:  alu_res = a_q - b_q;
      OP_OR:   alu_res = a_q | b_q;
      OP_LUI:  alu_res = b_q << 12;
      OP_SRL:  alu_res = a_q;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      cnt          <= '0;
      ALU_Result_o <= '0;
      Zero_o       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            a_q  <= A_i;
            b_q  <= B_i;
            op_q <= ALU_Operation_i;
            cnt  <= B_i[SHW-1:0];
          end
        end
        EXEC: begin
          if (shifting) begin
            a_q <= a_q >> 1;
            cnt <= cnt - 1'b1;
          end else begin
            ALU_Result_o <= alu_res;
            Zero_o       <= (alu_res == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);

endmodule

// File: tb/tb_alu_iterative.sv
// Self-checking bench for alu_iterative: directed vector table, corner sequences,
// and random operations against an arithmetic reference model.
module tb_alu_iterative;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_i;
  logic [3:0]   ALU_Operation_i;
  logic [W-1:0] A_i, B_i;
  logic         busy_o, done_o, Zero_o;
  logic [W-1:0] ALU_Result_o;

  int tests_run = 0;
  int tests_failed = 0;

  alu_iterative #(.WIDTH(W)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .ALU_Operation_i (ALU_Operation_i),
    .A_i             (A_i),
    .B_i             (B_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .ALU_Result_o    (ALU_Result_o),
    .Zero_o          (Zero_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp_res;
    logic         exp_zero;
    int           exp_lat;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic on the operation definitions.
  function automatic logic [W-1:0] model_res(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    int s;
    s = int'(b % W);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd3:    return a | b;
      4'd5:    return b * (1 << 12);
      4'd6:    return a / (64'd1 << s);
      default: return '0;
    endcase
  endfunction

  function automatic int model_lat(input logic [3:0] op, input logic [W-1:0] b);
    return (op == 4'd6) ? 1 + int'(b % W) : 1;
  endfunction

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] er, input logic ez,
                        input int el);
    int lat;
    @(negedge clk);
    start_i = 1'b1; ALU_Operation_i = op; A_i = a; B_i = b;
    @(posedge clk); #1;
    check({tag, " busy_after_accept"}, {31'b0, busy_o}, 1);
    @(negedge clk);
    start_i = 1'b0;
    A_i = $urandom; B_i = $urandom; ALU_Operation_i = 4'($urandom);
    lat = 0;
    while (!done_o && lat < W + 4) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done_o) begin
      check({tag, " timeout_waiting_done"}, 0, 1);
    end else begin
      check({tag, " latency"}, lat, el);
      check({tag, " result"}, ALU_Result_o, er);
      check({tag, " zero"}, {31'b0, Zero_o}, {31'b0, ez});
      check({tag, " busy_in_done"}, {31'b0, busy_o}, 1);
    end
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, {31'b0, done_o}, 0);
    check({tag, " result_hold_idle"}, ALU_Result_o, er);
  endtask

  initial begin
    vecs[0]  = '{op: 4'h0, a: 32'd5,         b: 32'd7,          exp_res: 32'd12,        exp_zero: 1'b0, exp_lat: 1};
    vecs[1]  = '{op: 4'h1, a: 32'h1234,      b: 32'h1234,       exp_res: 32'd0,         exp_zero: 1'b1, exp_lat: 1};
    vecs[2]  = '{op: 4'h1, a: 32'd0,         b: 32'd1,          exp_res: 32'hFFFFFFFF,  exp_zero: 1'b0, exp_lat: 1};
    vecs[3]  = '{op: 4'h6, a: 32'h80000000,  b: 32'd31,         exp_res: 32'd1,         exp_zero: 1'b0, exp_lat: 32};
    vecs[4]  = '{op: 4'h6, a: 32'hF0,        b: 32'h25,         exp_res: 32'h7,         exp_zero: 1'b0, exp_lat: 6};
    vecs[5]  = '{op: 4'h6, a: 32'hDEADBEEF,  b: 32'd0,          exp_res: 32'hDEADBEEF,  exp_zero: 1'b0, exp_lat: 1};
    vecs[6]  = '{op: 4'h5, a: 32'hAAAA5555,  b: 32'h00012345,   exp_res: 32'h12345000,  exp_zero: 1'b0, exp_lat: 1};
    vecs[7]  = '{op: 4'h3, a: 32'hF0,        b: 32'h0F,         exp_res: 32'hFF,        exp_zero: 1'b0, exp_lat: 1};
    vecs[8]  = '{op: 4'hF, a: 32'h12345678,  b: 32'h9ABCDEF0,   exp_res: 32'd0,         exp_zero: 1'b1, exp_lat: 1};
    vecs[9]  = '{op: 4'h6, a: 32'h12345678,  b: 32'hFFFFFFE0,   exp_res: 32'h12345678,  exp_zero: 1'b0, exp_lat: 1};
    vecs[10] = '{op: 4'h0, a: 32'hFFFFFFFF,  b: 32'd2,          exp_res: 32'd1,         exp_zero: 1'b0, exp_lat: 1};

    reset = 1'b0; start_i = 1'b1; ALU_Operation_i = 4'h0; A_i = 32'd3; B_i = 32'd4;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'b0, busy_o}, 0);
    check("reset done", {31'b0, done_o}, 0);
    check("reset result", ALU_Result_o, 0);
    check("reset zero", {31'b0, Zero_o}, 1);
    @(negedge clk);
    reset = 1'b1; start_i = 1'b0;

    for (int i = 0; i < 11; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].exp_res, vecs[i].exp_zero, vecs[i].exp_lat);

    // Reset asserted in the middle of a long shift aborts it without a done pulse.
    @(negedge clk);
    start_i = 1'b1; ALU_Operation_i = 4'h6; A_i = 32'hFFFFFFFF; B_i = 32'd20;
    @(posedge clk); #1;
    @(negedge clk); start_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("abort pre_reset done c%0d", k), {31'b0, done_o}, 0);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("abort busy", {31'b0, busy_o}, 0);
    check("abort done", {31'b0, done_o}, 0);
    check("abort result", ALU_Result_o, 0);
    check("abort zero", {31'b0, Zero_o}, 1);
    @(negedge clk); reset = 1'b1;
    begin
      int pulses;
      pulses = 0;
      repeat (30) begin
        @(posedge clk); #1;
        if (done_o) pulses++;
      end
      check("abort no_late_done", pulses, 0);
    end

    // start_i held high: accepted only from IDLE, so one operation per three cycles.
    @(negedge clk);
    start_i = 1'b1; ALU_Operation_i = 4'h0; A_i = 32'd1; B_i = 32'd1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      check($sformatf("stream done c%0d", c), {31'b0, done_o}, (c % 3 == 2) ? 1 : 0);
      check($sformatf("stream busy c%0d", c), {31'b0, busy_o}, (c % 3 == 0) ? 0 : 1);
      if (c % 3 == 2) check($sformatf("stream result c%0d", c), ALU_Result_o, 2);
    end
    @(negedge clk); start_i = 1'b0;
    repeat (3) @(posedge clk);

    for (int i = 0; i < 40; i++) begin
      logic [3:0]   op;
      logic [W-1:0] a, b, r;
      logic [3:0]   valid_ops[5] = '{4'h0, 4'h1, 4'h3, 4'h5, 4'h6};
      op = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : valid_ops[$urandom_range(4)];
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(7) == 0) b = a;
      r  = model_res(op, a, b);
      run_op($sformatf("rnd%0d op%h", i, op), op, a, b, r, (r == '0), model_lat(op, b));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
